// File: rtl/seq_gen.sv
// Serial pattern transmitter: on an accepted start, sends PATTERN (MSB first)
// N times with G idle cycles between repetitions, then pulses done.
module seq_gen #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter int               CNT_W   = 4
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [3:0]       gap_cnt,
  output logic             val,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       status_view
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           r_status;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rep;
  logic [3:0]       r_gap;
  logic [3:0]       r_gap_len;
  logic             r_val;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  // Outputs are registered from the current state, so they trail r_state by
  // one cycle; stop clears them at the same edge it forces IDLE.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_status  <= IDLE;
      r_idx     <= '0;
      r_rep     <= '0;
      r_gap     <= '0;
      r_gap_len <= '0;
      r_val     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_val    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= IDLE;
      if (stop) begin
        r_state <= IDLE;
      end else begin
        r_status <= r_state;
        case (r_state)
          IDLE: begin
            if (start) begin
              r_rep     <= repeat_cnt;
              r_gap_len <= gap_cnt;
              r_idx     <= IDX_TOP;
              r_state   <= (repeat_cnt == '0) ? DONE : SEND;
            end
          end
          SEND: begin
            r_val   <= PATTERN[r_idx];
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            if (r_idx == '0) begin
              if (r_rep > CNT_W'(1)) begin
                r_rep <= r_rep - CNT_W'(1);
                r_idx <= IDX_TOP;
                if (r_gap_len != '0) begin
                  r_gap   <= r_gap_len;
                  r_state <= GAP;
                end
              end else begin
                r_state <= DONE;
              end
            end else begin
              r_idx <= r_idx - IDX_W'(1);
            end
          end
          GAP: begin
            r_busy <= 1'b1;
            if (r_gap <= 4'd1) r_state <= SEND;
            else               r_gap   <= r_gap - 4'd1;
          end
          DONE: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign val         = r_val;
  assign valid       = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign status_view = {6'd0, r_status};

endmodule
